// File: rtl/nab_axi_pkg.sv
// rtl/nab_axi_pkg.sv - FSM state types, response codes and register indices for the nab AXI4-Lite block
package nab_axi_pkg;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACCEPT,
        R_RESP
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DBG      = 3;
    localparam int PWM_DIV  = 8;
    localparam int PWM_DUTY = 9;

endpackage

// File: rtl/nab_axi_reg_bank.sv
// rtl/nab_axi_reg_bank.sv - register storage, byte-lane merge and reg_wr pulses; AXI_REGS_WSTRB_EN enables lane writes
module nab_axi_reg_bank
    import nab_axi_pkg::*;
#(
    parameter int NUM_REGS = 11,
    parameter int IDX_W    = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit,
    input  logic [IDX_W-1:0]         idx,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr
);

    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_q;
    logic [NUM_REGS-1:0] reg_wr_d;
    logic [3:0]          lane_en;
    logic [31:0]         lane_mask;

    always_comb begin
`ifdef AXI_REGS_WSTRB_EN
        lane_en = wstrb;
`else
        // Strobes are ignored: every lane is forced on.
        lane_en = wstrb | 4'hF;
`endif
        lane_mask = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_wr_d[k] = commit && (idx == IDX_W'(k));
            regs_d[k]   = reg_wr_d[k] ? ((regs_q[k] & ~lane_mask) | (wdata & lane_mask))
                                      : regs_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
            reg_wr_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
            reg_wr_q <= reg_wr_d;
        end
    end

    always_comb begin
        reg_q = '0;
        for (int k = 0; k < NUM_REGS; k++) reg_q[32*k +: 32] = regs_q[k];
    end

    assign reg_wr = reg_wr_q;

endmodule

// File: rtl/nab_axi_lite_regs.sv
// rtl/nab_axi_lite_regs.sv - AXI4-Lite responder with write/read FSMs and address decode; AXI_REGS_WSTRB_EN enables byte-lane writes
module nab_axi_lite_regs
    import nab_axi_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int NUM_REGS = 11
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESET,
    input  logic [ADDR_W-1:0]      S_AXI_AWADDR,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [31:0]            S_AXI_WDATA,
    input  logic [3:0]             S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [ADDR_W-1:0]      S_AXI_ARADDR,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [31:0]            S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]    reg_wr
);

    localparam int                IDX_W    = ADDR_W - 2;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);

    wr_state_t        wr_state_q, wr_state_d;
    rd_state_t        rd_state_q, rd_state_d;
    logic             rst_done_q, rst_done_d;
    logic             awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic             bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d, wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d, ar_idx_q, ar_idx_d;
    logic             aw_hs, w_hs, ar_hs, aw_in_range, ar_in_range, commit;
    logic [31:0]      rd_word;

    assign aw_hs       = S_AXI_AWVALID && awready_q;
    assign w_hs        = S_AXI_WVALID && wready_q;
    assign ar_hs       = S_AXI_ARVALID && arready_q;
    assign aw_in_range = aw_idx_q <= LAST_IDX;
    assign ar_in_range = ar_idx_q <= LAST_IDX;
    assign commit      = (wr_state_q == W_COMMIT) && aw_in_range;
    assign rst_done_d  = 1'b1;

    // READY pulses for one cycle only; accepts are blocked on the first edge out of reset.
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        aw_idx_d   = aw_hs ? IDX_W'(S_AXI_AWADDR >> 2) : aw_idx_q;
        wdata_d    = w_hs ? S_AXI_WDATA : wdata_q;
        wstrb_d    = w_hs ? S_AXI_WSTRB : wstrb_q;
        case (wr_state_q)
            W_IDLE: begin
                awready_d = rst_done_q && S_AXI_AWVALID && !awready_q;
                wready_d  = rst_done_q && S_AXI_WVALID && !wready_q;
                if (aw_hs && w_hs) wr_state_d = W_COMMIT;
                else if (aw_hs)    wr_state_d = W_HAVE_A;
                else if (w_hs)     wr_state_d = W_HAVE_D;
            end
            W_HAVE_A: begin
                wready_d = S_AXI_WVALID && !wready_q;
                if (w_hs) wr_state_d = W_COMMIT;
            end
            W_HAVE_D: begin
                awready_d = S_AXI_AWVALID && !awready_q;
                if (aw_hs) wr_state_d = W_COMMIT;
            end
            W_COMMIT: begin
                bvalid_d   = 1'b1;
                bresp_d    = aw_in_range ? RESP_OKAY : RESP_SLVERR;
                wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (ar_idx_q == IDX_W'(k)) rd_word = reg_q[32*k +: 32];
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        ar_idx_d   = ar_hs ? IDX_W'(S_AXI_ARADDR >> 2) : ar_idx_q;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = rst_done_q && S_AXI_ARVALID && !arready_q;
                if (ar_hs) rd_state_d = R_ACCEPT;
            end
            R_ACCEPT: begin
                rvalid_d   = 1'b1;
                rdata_d    = ar_in_range ? rd_word : 32'h0;
                rresp_d    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
                rd_state_d = R_RESP;
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            rst_done_q <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_idx_q   <= '0;
            ar_idx_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            rst_done_q <= rst_done_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_idx_q   <= aw_idx_d;
            ar_idx_q   <= ar_idx_d;
        end
    end

    nab_axi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk    (S_AXI_ACLK),
        .rst    (S_AXI_ARESET),
        .commit (commit),
        .idx    (aw_idx_q),
        .wdata  (wdata_q),
        .wstrb  (wstrb_q),
        .reg_q  (reg_q),
        .reg_wr (reg_wr)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule

// File: doc/nab_axi_lite_regs.md
# nab_axi_lite_regs

AXI4-Lite responder and register bank for the neuromorphic ASIC bridge. It terminates the host's AXI4-Lite write and read channels and holds NUM_REGS 32-bit read/write control registers, covering the debug/clock-select, PWM divider and PWM duty-cycle registers. Register contents and per-register write strobes are driven to the bridge datapath (network interface, clock dividers, PWM block).

## Interface
- ADDR_W, 9: AXI address width in bits.
- NUM_REGS, 11: number of 32-bit registers, at byte addresses 0x00 .. 4*(NUM_REGS-1).
- S_AXI_ACLK  in  1  the single clock; all logic is on the rising edge.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  ADDR_W; S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- reg_q  out  32*NUM_REGS  flattened register contents; register k occupies bits [32k+31:32k].
- reg_wr  out  NUM_REGS  one-cycle pulse on bit k when register k is committed.

## Operation
- **Address decode:** word index is ADDR[ADDR_W-1:2]; bits [1:0] are ignored. An index ≥ NUM_REGS is out of range.
- **Write FSM states:**
  - W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP.
  - AW and W are accepted independently and in either order. Each is latched on its own VALID&READY.
  - When both are held, go to W_COMMIT. In W_COMMIT, write the register, pulse reg_wr, and load BVALID.
  - W_RESP holds BVALID until BREADY, then returns to W_IDLE.
  - No new AW/W is accepted while in W_COMMIT or W_RESP.
- **Read FSM states:** R_IDLE, R_ACCEPT, R_RESP. In R_ACCEPT, capture the address and load RDATA/RRESP. In R_RESP, hold RVALID until RREADY.
- **Responses:**
  - In range: OKAY (2'b00).
  - Out-of-range write: SLVERR (2'b10); no register changes; no reg_wr pulse.
  - Out-of-range read: SLVERR with RDATA = 0.
- **Channel independence:** read and write channels are fully independent. A read and a commit to the same register in the same cycle return the pre-write value.
- **Reset values:** all registers 0x0000_0000.

## Timing
- **Reset:** asynchronous. While asserted, and for the first edge after release:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_wr = 0.
  - BRESP, RRESP, RDATA = 0; reg_q = 0.
  - Both FSMs are idle.
  - Reset mid-transaction discards the transaction with no register update and no response.
- **READY signals:** registered. Each READY rises the cycle after the matching VALID is seen in an accepting state and stays high for exactly one cycle. Consequently every accept produces a clean 0→1→0 READY edge.
- **Write latency:** if AWVALID and WVALID are both presented at edge N:
  - AWREADY and WREADY are high after edge N.
  - The handshake completes at edge N+1.
  - The commit happens at edge N+2: reg_q updates, and reg_wr and BVALID are high after that edge.
  - Skew between AW and W adds the skew to this latency.
- **Read latency:** for ARVALID at edge N, ARREADY is high after N, and RVALID and RDATA are valid after N+2.
- **Response hold:** BVALID/RVALID deassert on the edge where READY is sampled high. If BREADY/RREADY are already high, the response lasts one cycle.
- **Back-to-back:** the earliest next accept is the cycle after the response handshake.

## Configuration
- **AXI_REGS_WSTRB_EN defined:** a commit updates only the byte lanes whose WSTRB bit is 1. WSTRB = 4'b0000 leaves the register unchanged but still produces reg_wr and an OKAY response.
- **Not defined:** WSTRB is ignored and every commit writes all 32 bits.

## Structure
- **Package nab_axi_pkg:**
  - write-FSM and read-FSM state typedefs;
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the register index constants (DBG = 3, PWM_DIV = 8, PWM_DUTY = 9).
- **Sub-module nab_axi_reg_bank:** the storage array, byte-lane merge and reg_wr generation. Its inputs are commit, index and data; its outputs are reg_q and reg_wr. The top level holds both FSMs and the decode.

## Test plan
- **Sequential write/readback:** write 0xDEADBEEF to addresses 0x00..0x28 in steps of 4, then read all 11 → each read returns 0xDEADBEEF with RRESP = OKAY, and reg_wr pulsed once per register.
- **Data before address:** WVALID with 0x000000CC three cycles before AWVALID at 0x0C → reg_q[127:96] = 0xCC and exactly one BVALID; read of 0x0C returns 0xCC.
- **Out-of-range access:** write 0x12345678 to 0x2C → BRESP = SLVERR and no reg_wr. Read of 0x2C → RRESP = SLVERR with RDATA = 0. Registers 0x00..0x28 are unchanged.
- **Backpressure:** hold BREADY = 0 for 20 cycles after a write to 0x20 → BVALID stays high, AWREADY/WREADY stay low, and a concurrent read of 0x24 still completes.
- **Reset mid-write:** assert S_AXI_ARESET after the AW handshake only → all outputs 0, reg_q all zero, and a subsequent write of 0x1A to 0x20 completes normally.
- **Byte strobes:** with AXI_REGS_WSTRB_EN, write 0xAABBCCDD with WSTRB = 4'b0101 to a register holding 0 → readback is 0x00BB00DD. Without the macro, readback is 0xAABBCCDD.
